decode_stage_pipe: RTL
======================

Name: decode_stage_pipe

Overview:
- Parametrised successor to the single-cycle decode tract. Decodes an instruction, reads the internal register file with write-back bypass, and detects load-use hazards.
- Registers the full decoded bundle into an ID/EX pipeline register with valid, hold, flush and bubble insertion.
- Sits between the IF/ID register and the execute stage of the 5-stage RISC-V core.
- Also keeps a saturating load-use stall counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of register data, PC and immediate.
- NREGS, 32, architectural register count; address width AW = clog2(NREGS).
- BYPASS_EN, 1, 1 = same-cycle write-back-to-decode forwarding; 0 = raw register-file read.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  XLEN  PC of InstrD
- PCPlus4D  in  XLEN  PC+4 of InstrD
- ValidD  in  1  InstrD is a real instruction
- ResultW  in  XLEN  write-back data
- RdW  in  AW  write-back destination
- RegWriteW  in  1  write-back enable
- FlushD  in  1  kill the instruction currently in decode (taken branch/jump)
- HoldE  in  1  downstream stall; ID/EX must not change
- RD1E, RD2E  out  XLEN  registered operands
- ImmExtE  out  XLEN  registered sign-extended immediate
- PCE, PCPlus4E  out  XLEN  registered PC values
- Rs1E, Rs2E, RdE  out  AW  registered register indices
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, SumSrcE, ControlSignalE  out  1 each  registered control
- ResultSrcE  out  2, ALUControlE  out  4, StoreSrcE  out  2, TypeBranchE  out  3, LoadSrcE  out  3  registered control
- ValidE  out  1  ID/EX holds a real instruction
- StallD  out  1  combinational; fetch and IF/ID must hold
- StallCount  out  CNT_W  saturating load-use stall counter

Behaviour:
- Decode uses the team ControlUnit and ImmediateExtension.
  - Rs1D = InstrD[19:15], Rs2D = InstrD[24:20], RdD = InstrD[11:7], each truncated to AW.
- Register file: NREGS x XLEN with x0 hardwired to 0.
  - Write occurs at the rising edge when RegWriteW=1 and RdW!=0.
  - Reads are combinational.
  - Register contents are not cleared by reset.
- Bypass (BYPASS_EN=1): if RegWriteW=1, RdW!=0 and RdW==Rs1D, the read value is ResultW (same rule for Rs2D). Index 0 always reads 0.
- Load-use hazard: hz = ValidE & RegWriteE & (ResultSrcE==2'b01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D) & ValidD.
- StallD = HoldE | (hz & ~FlushD).
- ID/EX update at each rising edge, first matching condition wins:
  1. rst_n=0: all outputs 0, StallCount 0.
  2. FlushD=1: bubble is loaded, overriding HoldE.
  3. HoldE=1: all ID/EX fields keep their value.
  4. hz=1: bubble is loaded; IF/ID is held via StallD.
  5. Otherwise: decoded bundle is loaded, with ValidE=ValidD.
- Bubble: every control output 0, ValidE=0, and data/index fields 0.
- When ValidD=0, the bundle is loaded but every control output is forced to 0 (no stray writes).
- Latency: one cycle from decode to E outputs. A load followed by a dependent instruction costs exactly one bubble.
- StallCount increments by 1 on every edge where case 4 applies, and saturates at 2^CNT_W-1.
- Reset mid-hold or mid-hazard: reset wins; the next cycle starts clean, with ValidE=0 and StallD=HoldE.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all E outputs 0, ValidE=0, StallCount=0.
- Bypass: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, InstrD=add x6,x5,x5 -> next cycle RD1E=RD2E=0xDEADBEEF. Repeat with BYPASS_EN=0 -> old value of x5.
- x0 protection: write 0x1234 to x0, then decode add x1,x0,x0 -> RD1E=RD2E=0.
- Load-use: lw x7,0(x2) then add x8,x7,x1 -> StallD=1 for one cycle, one bubble (ValidE=0) in E, then add in E, StallCount=1. Repeat with rd=x0 -> no stall.
- Flush vs hold: FlushD=1 and HoldE=1 on the same edge -> ValidE=0 and RegWriteE=0 next cycle. HoldE=1 alone for 3 cycles -> ID/EX unchanged and StallD=1.
- Saturation: with CNT_W=2, force 5 load-use stalls -> StallCount=3.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage with register file, write-back bypass, load-use hazard
// detection, ID/EX pipeline register and a saturating load-use stall counter.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   InstrD, PCD, PCPlus4D      instruction and PCs from IF/ID
//   ValidD                     InstrD is a real instruction
//   ResultW, RdW, RegWriteW    write-back port
//   FlushD, HoldE              kill decode / freeze ID/EX
//   *E                         registered ID/EX bundle
//   StallD                     combinational fetch / IF/ID hold request
//   StallCount                 saturating count of load-use bubbles
module decode_stage_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter bit          BYPASS_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              InstrD,
  input  logic [XLEN-1:0]          PCD,
  input  logic [XLEN-1:0]          PCPlus4D,
  input  logic                     ValidD,
  input  logic [XLEN-1:0]          ResultW,
  input  logic [$clog2(NREGS)-1:0] RdW,
  input  logic                     RegWriteW,
  input  logic                     FlushD,
  input  logic                     HoldE,
  output logic [XLEN-1:0]          RD1E,
  output logic [XLEN-1:0]          RD2E,
  output logic [XLEN-1:0]          ImmExtE,
  output logic [XLEN-1:0]          PCE,
  output logic [XLEN-1:0]          PCPlus4E,
  output logic [$clog2(NREGS)-1:0] Rs1E,
  output logic [$clog2(NREGS)-1:0] Rs2E,
  output logic [$clog2(NREGS)-1:0] RdE,
  output logic                     RegWriteE,
  output logic                     MemWriteE,
  output logic                     JumpE,
  output logic                     BranchE,
  output logic                     ALUSrcE,
  output logic                     ALUSrcAE,
  output logic                     SumSrcE,
  output logic                     ControlSignalE,
  output logic [1:0]               ResultSrcE,
  output logic [3:0]               ALUControlE,
  output logic [1:0]               StoreSrcE,
  output logic [2:0]               TypeBranchE,
  output logic [2:0]               LoadSrcE,
  output logic                     ValidE,
  output logic                     StallD,
  output logic [CNT_W-1:0]         StallCount
);

  localparam int unsigned AW = $clog2(NREGS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic       alu_src_a;
    logic       sum_src;
    logic       ctrl_sig;
    logic [1:0] result_src;
    logic [3:0] alu_control;
    logic [1:0] store_src;
    logic [2:0] type_branch;
    logic [2:0] load_src;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    ctrl_t           ctrl;
    logic            valid;
  } idex_t;

  logic [XLEN-1:0]  rf [NREGS];
  logic [AW-1:0]    rs1_d, rs2_d, rd_d;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rd1, rd2, imm;
  ctrl_t            ctrl;
  idex_t            idex_q, idex_d, bundle;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;

  assign rs1_d  = AW'(InstrD[19:15]);
  assign rs2_d  = AW'(InstrD[24:20]);
  assign rd_d   = AW'(InstrD[11:7]);
  assign funct3 = InstrD[14:12];

  // Register file write port; x0 is never written and contents survive reset.
  always_ff @(posedge clk) begin
    if (RegWriteW && (RdW != '0)) rf[RdW] <= ResultW;
  end

  // Read ports with optional same-cycle write-back forwarding.
  always_comb begin
    rd1 = rf[rs1_d];
    rd2 = rf[rs2_d];
    if (BYPASS_EN && RegWriteW && (RdW != '0)) begin
      if (RdW == rs1_d) rd1 = ResultW;
      if (RdW == rs2_d) rd2 = ResultW;
    end
    if (rs1_d == '0) rd1 = '0;
    if (rs2_d == '0) rd2 = '0;
  end

  // Control decode; a non-valid slot never asserts any control.
  always_comb begin
    ctrl = '0;
    case (InstrD[6:0])
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = {InstrD[30], funct3};
      end
      OP_I: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = {(funct3 == 3'b101) & InstrD[30], funct3};
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 2'b01;
        ctrl.load_src   = funct3;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.store_src = funct3[1:0];
      end
      OP_BR: begin
        ctrl.branch      = 1'b1;
        ctrl.type_branch = funct3;
        ctrl.alu_control = 4'b1000;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = 2'b10;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = 2'b10;
        ctrl.sum_src    = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 2'b11;
        ctrl.ctrl_sig   = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.ctrl_sig  = 1'b1;
      end
      default: ;
    endcase
    if (!ValidD) ctrl = '0;
  end

  // Immediate extension by instruction format.
  always_comb begin
    imm = '0;
    case (InstrD[6:0])
      OP_I, OP_LOAD, OP_JALR: imm = XLEN'($signed(InstrD[31:20]));
      OP_STORE:               imm = XLEN'($signed({InstrD[31:25], InstrD[11:7]}));
      OP_BR:                  imm = XLEN'($signed({InstrD[31], InstrD[7], InstrD[30:25],
                                                   InstrD[11:8], 1'b0}));
      OP_JAL:                 imm = XLEN'($signed({InstrD[31], InstrD[19:12], InstrD[20],
                                                   InstrD[30:21], 1'b0}));
      OP_LUI, OP_AUIPC:       imm = XLEN'($signed({InstrD[31:12], 12'b0}));
      default: ;
    endcase
  end

  // Load in E whose destination is a source of the instruction in decode.
  assign hz = idex_q.valid & idex_q.ctrl.reg_write & (idex_q.ctrl.result_src == 2'b01) &
              (idex_q.rd != '0) & ((idex_q.rd == rs1_d) | (idex_q.rd == rs2_d)) & ValidD;

  assign StallD = HoldE | (hz & ~FlushD);

  always_comb begin
    bundle       = '0;
    bundle.rd1   = rd1;
    bundle.rd2   = rd2;
    bundle.imm   = imm;
    bundle.pc    = PCD;
    bundle.pc4   = PCPlus4D;
    bundle.rs1   = rs1_d;
    bundle.rs2   = rs2_d;
    bundle.rd    = rd_d;
    bundle.ctrl  = ctrl;
    bundle.valid = ValidD;
  end

  // ID/EX next state: flush beats hold, hold beats hazard bubble.
  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (FlushD) begin
      idex_d = '0;
    end else if (HoldE) begin
      idex_d = idex_q;
    end else if (hz) begin
      idex_d = '0;
      cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      idex_d = bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign RD1E           = idex_q.rd1;
  assign RD2E           = idex_q.rd2;
  assign ImmExtE        = idex_q.imm;
  assign PCE            = idex_q.pc;
  assign PCPlus4E       = idex_q.pc4;
  assign Rs1E           = idex_q.rs1;
  assign Rs2E           = idex_q.rs2;
  assign RdE            = idex_q.rd;
  assign RegWriteE      = idex_q.ctrl.reg_write;
  assign MemWriteE      = idex_q.ctrl.mem_write;
  assign JumpE          = idex_q.ctrl.jump;
  assign BranchE        = idex_q.ctrl.branch;
  assign ALUSrcE        = idex_q.ctrl.alu_src;
  assign ALUSrcAE       = idex_q.ctrl.alu_src_a;
  assign SumSrcE        = idex_q.ctrl.sum_src;
  assign ControlSignalE = idex_q.ctrl.ctrl_sig;
  assign ResultSrcE     = idex_q.ctrl.result_src;
  assign ALUControlE    = idex_q.ctrl.alu_control;
  assign StoreSrcE      = idex_q.ctrl.store_src;
  assign TypeBranchE    = idex_q.ctrl.type_branch;
  assign LoadSrcE       = idex_q.ctrl.load_src;
  assign ValidE         = idex_q.valid;
  assign StallCount     = cnt_q;

endmodule
